// File: rtl/routed_port_pkg.sv
// Shared definitions for routed_port_handler: port indices, the buffered request
// record and the dimension-ordered routing function.
package routed_port_pkg;

    localparam int NUM_PORTS = 5;
    localparam int PORT_N    = 0;
    localparam int PORT_S    = 1;
    localparam int PORT_E    = 2;
    localparam int PORT_W    = 3;
    localparam int PORT_L    = 4;

    // The record is sized for the widest supported instance; narrower instances
    // zero-extend into it and unused upper bits are trimmed by synthesis.
    localparam int MAX_COORD_W    = 8;
    localparam int MAX_MEM_ADDR_W = 24;
    localparam int MAX_ADDR_W     = 2 * MAX_COORD_W;
    localparam int MAX_DEST_W     = MAX_ADDR_W + MAX_MEM_ADDR_W;

    typedef struct packed {
        logic [MAX_DEST_W-1:0] dest;
        logic [MAX_ADDR_W-1:0] requester;
        logic                  rd;
        logic                  wr;
    } portReq_t;

    // One-hot output port for a destination; yx selects which axis is resolved first.
    function automatic logic [NUM_PORTS-1:0] route_sel(
        input logic [MAX_COORD_W-1:0] localX,
        input logic [MAX_COORD_W-1:0] localY,
        input logic [MAX_COORD_W-1:0] destX,
        input logic [MAX_COORD_W-1:0] destY,
        input logic                   yx
    );
        logic [NUM_PORTS-1:0] sel;
        sel = '0;
        if (yx) begin
            if (destY > localY)      sel[PORT_N] = 1'b1;
            else if (destY < localY) sel[PORT_S] = 1'b1;
            else if (destX > localX) sel[PORT_E] = 1'b1;
            else if (destX < localX) sel[PORT_W] = 1'b1;
            else                     sel[PORT_L] = 1'b1;
        end else begin
            if (destX > localX)      sel[PORT_E] = 1'b1;
            else if (destX < localX) sel[PORT_W] = 1'b1;
            else if (destY > localY) sel[PORT_N] = 1'b1;
            else if (destY < localY) sel[PORT_S] = 1'b1;
            else                     sel[PORT_L] = 1'b1;
        end
        return sel;
    endfunction

endpackage

// File: rtl/port_req_fifo.sv
// Synchronous request FIFO with occupancy count and a registered write-ready
// that never depends combinationally on the read side.
module port_req_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       wrEn,
    input  logic [WIDTH-1:0]           wrData,
    input  logic                       rdEn,
    output logic [WIDTH-1:0]           rdData,
    output logic                       empty,
    output logic                       wrReady,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wrPtr;
    logic [PTR_W-1:0] rdPtr;
    logic [CNT_W-1:0] countNext;
    logic             full;
    logic             doWr;
    logic             doRd;

    assign full      = (count == CNT_W'(DEPTH));
    assign empty     = (count == '0);
    assign doWr      = wrEn && !full;
    assign doRd      = rdEn && !empty;
    assign countNext = count + CNT_W'(doWr) - CNT_W'(doRd);
    assign rdData    = mem[rdPtr];

    // DEPTH is a power of two, so the pointers wrap by plain overflow.
    always_ff @(posedge clk) begin
        if (reset) begin
            wrPtr   <= '0;
            rdPtr   <= '0;
            count   <= '0;
            wrReady <= 1'b0;
        end else begin
            if (doWr) wrPtr <= wrPtr + 1'b1;
            if (doRd) rdPtr <= rdPtr + 1'b1;
            count   <= countNext;
            wrReady <= (countNext != CNT_W'(DEPTH));
        end
    end

    always_ff @(posedge clk) begin
        if (doWr) mem[wrPtr] <= wrData;
    end

endmodule

// File: rtl/routed_port_handler.sv
// Router input port: buffers requests, routes them dimension-ordered (XY or YX) and
// presents them on a registered handshake stage. Define ROUTE_STATS_EN for per-port counters.
module routed_port_handler
    import routed_port_pkg::*;
#(
    parameter int COORD_W    = 3,
    parameter int MEM_ADDR_W = 8,
    parameter int DEPTH      = 4,
    parameter int ROUTE_YX   = 0
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [2*COORD_W-1:0]            localRouterAddress,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [2*COORD_W+MEM_ADDR_W-1:0] destinationAddressIn,
    input  logic [2*COORD_W-1:0]            requesterAddressIn,
    input  logic                            readIn,
    input  logic                            writeIn,
    output logic                            out_valid,
    input  logic [NUM_PORTS-1:0]            out_ready,
    output logic [NUM_PORTS-1:0]            outputPortSelect,
    output logic [2*COORD_W+MEM_ADDR_W-1:0] destinationAddressOut,
    output logic [2*COORD_W-1:0]            requesterAddressOut,
    output logic                            readOut,
    output logic                            writeOut,
    output logic                            memRead,
    output logic                            memWrite,
    output logic                            protocol_err,
`ifdef ROUTE_STATS_EN
    output logic [16*NUM_PORTS-1:0]         stats_count,
`endif
    output logic [$clog2(DEPTH):0]          fifo_count
);

    localparam int ADDR_W = 2 * COORD_W;
    localparam int DEST_W = ADDR_W + MEM_ADDR_W;

    portReq_t             wrReq;
    portReq_t             headReq;
    logic                 fifoEmpty;
    logic                 accept;
    logic                 badOp;
    logic                 granted;
    logic                 loadStage;
    logic [NUM_PORTS-1:0] headSel;
    logic                 unusedHeadBits;

    // Handshake: a request transfers on any edge where in_valid && in_ready. Only
    // single-op requests are stored; both-ops is consumed and flagged, no-op is dropped.
    // On the output side a request completes when out_valid and its selected port's
    // out_ready are both high; ready bits of other ports are ignored.
    assign accept    = in_valid && in_ready && (readIn ^ writeIn);
    assign badOp     = in_valid && in_ready && readIn && writeIn;
    assign granted   = out_valid && |(out_ready & outputPortSelect);
    assign loadStage = (!out_valid || granted) && !fifoEmpty;

    always_comb begin
        wrReq           = '0;
        wrReq.dest      = MAX_DEST_W'(destinationAddressIn);
        wrReq.requester = MAX_ADDR_W'(requesterAddressIn);
        wrReq.rd        = readIn;
        wrReq.wr        = writeIn;
    end

    port_req_fifo #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(portReq_t))
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .wrEn    (accept),
        .wrData  (wrReq),
        .rdEn    (loadStage),
        .rdData  (headReq),
        .empty   (fifoEmpty),
        .wrReady (in_ready),
        .count   (fifo_count)
    );

    assign headSel = route_sel(
        MAX_COORD_W'(localRouterAddress[ADDR_W-1:COORD_W]),
        MAX_COORD_W'(localRouterAddress[COORD_W-1:0]),
        MAX_COORD_W'(headReq.dest[MEM_ADDR_W+COORD_W +: COORD_W]),
        MAX_COORD_W'(headReq.dest[MEM_ADDR_W +: COORD_W]),
        ROUTE_YX != 0
    );

    // Zero-extension padding of the shared record is never read back.
    assign unusedHeadBits = ^headReq;

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid             <= 1'b0;
            outputPortSelect      <= '0;
            destinationAddressOut <= '0;
            requesterAddressOut   <= '0;
            readOut               <= 1'b0;
            writeOut              <= 1'b0;
            memRead               <= 1'b0;
            memWrite              <= 1'b0;
            protocol_err          <= 1'b0;
        end else begin
            protocol_err <= badOp;
            if (loadStage) begin
                out_valid             <= 1'b1;
                outputPortSelect      <= headSel;
                destinationAddressOut <= headReq.dest[DEST_W-1:0];
                requesterAddressOut   <= headReq.requester[ADDR_W-1:0];
                readOut               <= headReq.rd;
                writeOut              <= headReq.wr;
                memRead               <= headSel[PORT_L] && headReq.rd;
                memWrite              <= headSel[PORT_L] && headReq.wr;
            end else if (granted) begin
                out_valid        <= 1'b0;
                outputPortSelect <= '0;
                memRead          <= 1'b0;
                memWrite         <= 1'b0;
            end
        end
    end

`ifdef ROUTE_STATS_EN
    for (genvar p = 0; p < NUM_PORTS; p++) begin : gStats
        logic [15:0] portCount;
        always_ff @(posedge clk) begin
            if (reset) begin
                portCount <= '0;
            end else if (granted && outputPortSelect[p] && portCount != 16'hFFFF) begin
                portCount <= portCount + 16'd1;
            end
        end
        assign stats_count[16*p +: 16] = portCount;
    end
`endif

endmodule

// File: tb/tb_routed_port_handler.sv
// Bench for routed_port_handler: routing table vectors, hand-written corner sequences
// and a randomized phase checked against a queue-level reference model.
module tb_routed_port_handler;

    localparam int DEPTH  = 4;
    localparam int ADDR_W = 6;
    localparam int DEST_W = 14;
    localparam int CNT_W  = 3;
    localparam logic [4:0] SEL_N = 5'b00001;
    localparam logic [4:0] SEL_S = 5'b00010;
    localparam logic [4:0] SEL_E = 5'b00100;
    localparam logic [4:0] SEL_W = 5'b01000;
    localparam logic [4:0] SEL_L = 5'b10000;

    logic              clk = 1'b0;
    logic              reset;
    logic [ADDR_W-1:0] localAddr;
    logic              in_valid;
    logic [DEST_W-1:0] destinationAddressIn;
    logic [ADDR_W-1:0] requesterAddressIn;
    logic              readIn;
    logic              writeIn;
    logic [4:0]        outReady;

    logic              in_ready, out_valid, readOut, writeOut, memRead, memWrite, protocol_err;
    logic [4:0]        outputPortSelect;
    logic [DEST_W-1:0] destinationAddressOut;
    logic [ADDR_W-1:0] requesterAddressOut;
    logic [CNT_W-1:0]  fifo_count;

    logic              in_readyY, out_validY, readOutY, writeOutY, memReadY, memWriteY, protocol_errY;
    logic [4:0]        outputPortSelectY;
    logic [DEST_W-1:0] destinationAddressOutY;
    logic [ADDR_W-1:0] requesterAddressOutY;
    logic [CNT_W-1:0]  fifo_countY;
`ifdef ROUTE_STATS_EN
    logic [79:0]       statsCount;
    logic [79:0]       statsCountY;
`endif

    routed_port_handler #(.COORD_W(3), .MEM_ADDR_W(8), .DEPTH(DEPTH), .ROUTE_YX(0)) dut (
        .clk(clk), .reset(reset), .localRouterAddress(localAddr),
        .in_valid(in_valid), .in_ready(in_ready),
        .destinationAddressIn(destinationAddressIn), .requesterAddressIn(requesterAddressIn),
        .readIn(readIn), .writeIn(writeIn),
        .out_valid(out_valid), .out_ready(outReady), .outputPortSelect(outputPortSelect),
        .destinationAddressOut(destinationAddressOut), .requesterAddressOut(requesterAddressOut),
        .readOut(readOut), .writeOut(writeOut), .memRead(memRead), .memWrite(memWrite),
        .protocol_err(protocol_err),
`ifdef ROUTE_STATS_EN
        .stats_count(statsCount),
`endif
        .fifo_count(fifo_count)
    );

    routed_port_handler #(.COORD_W(3), .MEM_ADDR_W(8), .DEPTH(DEPTH), .ROUTE_YX(1)) dutYx (
        .clk(clk), .reset(reset), .localRouterAddress(localAddr),
        .in_valid(in_valid), .in_ready(in_readyY),
        .destinationAddressIn(destinationAddressIn), .requesterAddressIn(requesterAddressIn),
        .readIn(readIn), .writeIn(writeIn),
        .out_valid(out_validY), .out_ready(outReady), .outputPortSelect(outputPortSelectY),
        .destinationAddressOut(destinationAddressOutY), .requesterAddressOut(requesterAddressOutY),
        .readOut(readOutY), .writeOut(writeOutY), .memRead(memReadY), .memWrite(memWriteY),
        .protocol_err(protocol_errY),
`ifdef ROUTE_STATS_EN
        .stats_count(statsCountY),
`endif
        .fifo_count(fifo_countY)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not reach the summary");
        $fatal(1, "watchdog expired");
    end

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Routing straight from the rules: resolve the first axis, then the second, else local.
    function automatic logic [4:0] refRoute(input int lx, input int ly, input int dx,
                                            input int dy, input bit yx);
        int first, second;
        logic [4:0] posFirst, negFirst, posSecond, negSecond;
        if (yx) begin
            first = dy - ly; second = dx - lx;
            posFirst = SEL_N; negFirst = SEL_S; posSecond = SEL_E; negSecond = SEL_W;
        end else begin
            first = dx - lx; second = dy - ly;
            posFirst = SEL_E; negFirst = SEL_W; posSecond = SEL_N; negSecond = SEL_S;
        end
        if (first > 0)  return posFirst;
        if (first < 0)  return negFirst;
        if (second > 0) return posSecond;
        if (second < 0) return negSecond;
        return SEL_L;
    endfunction

    typedef struct packed {
        logic [DEST_W-1:0] dest;
        logic [ADDR_W-1:0] req;
        logic              rd;
        logic              wr;
    } mreq_t;

    mreq_t      exp_q[$];
    mreq_t      mStage;
    bit         mValid = 1'b0;
    bit         mReady = 1'b0;
    bit         mErr = 1'b0;
    logic [4:0] mSel = '0;
    int         mStats[5] = '{0, 0, 0, 0, 0};
    bit         modelCheck = 1'b0;

    // Reference model: a request queue plus one presentation slot, updated per edge.
    always @(posedge clk) begin : model
        bit grant, acc, bad, ld;
        if (reset) begin
            exp_q.delete();
            mValid = 1'b0; mReady = 1'b0; mErr = 1'b0; mSel = '0;
            for (int p = 0; p < 5; p++) mStats[p] = 0;
        end else begin
            grant = mValid && ((outReady & mSel) != 5'b0);
            acc   = in_valid && mReady && (readIn != writeIn);
            bad   = in_valid && mReady && readIn && writeIn;
            if (grant)
                for (int p = 0; p < 5; p++)
                    if (mSel[p] && mStats[p] < 65535) mStats[p]++;
            ld = (!mValid || grant) && exp_q.size() > 0;
            if (ld) begin
                mStage = exp_q.pop_front();
                mSel = refRoute(int'(localAddr[5:3]), int'(localAddr[2:0]),
                                int'(mStage.dest[13:11]), int'(mStage.dest[10:8]), 1'b0);
                mValid = 1'b1;
            end else if (grant) begin
                mValid = 1'b0;
                mSel = '0;
            end
            if (acc) exp_q.push_back('{dest: destinationAddressIn, req: requesterAddressIn,
                                        rd: readIn, wr: writeIn});
            mReady = exp_q.size() < DEPTH;
            mErr = bad;
        end
    end

    always @(negedge clk) begin
        if (modelCheck) begin
            check("rnd_out_valid", out_valid, mValid);
            check("rnd_in_ready", in_ready, mReady);
            check("rnd_fifo_count", fifo_count, exp_q.size());
            check("rnd_sel", outputPortSelect, mSel);
            check("rnd_protocol_err", protocol_err, mErr);
            check("rnd_memRead", memRead, mValid && mSel[4] && mStage.rd);
            check("rnd_memWrite", memWrite, mValid && mSel[4] && mStage.wr);
            if (mValid) begin
                check("rnd_dest", destinationAddressOut, mStage.dest);
                check("rnd_requester", requesterAddressOut, mStage.req);
                check("rnd_readOut", readOut, mStage.rd);
                check("rnd_writeOut", writeOut, mStage.wr);
            end
`ifdef ROUTE_STATS_EN
            for (int p = 0; p < 5; p++) check("rnd_stats", statsCount[16*p +: 16], mStats[p]);
`endif
        end
    end

    // ---------------- driver tasks ----------------
    task automatic push(input logic [DEST_W-1:0] d, input logic [ADDR_W-1:0] r,
                        input logic rd, input logic wr);
        int waited = 0;
        @(negedge clk);
        while (!in_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) check("in_ready_wait", in_ready, 1);
        in_valid = 1'b1;
        destinationAddressIn = d;
        requesterAddressIn = r;
        readIn = rd;
        writeIn = wr;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        readIn = 1'b0;
        writeIn = 1'b0;
    endtask

    task automatic checkAllZero(input string tag);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_in_ready"}, in_ready, 0);
        check({tag, "_sel"}, outputPortSelect, 0);
        check({tag, "_dest"}, destinationAddressOut, 0);
        check({tag, "_requester"}, requesterAddressOut, 0);
        check({tag, "_rdwr"}, {readOut, writeOut}, 0);
        check({tag, "_mem"}, {memRead, memWrite}, 0);
        check({tag, "_protocol_err"}, protocol_err, 0);
        check({tag, "_fifo_count"}, fifo_count, 0);
`ifdef ROUTE_STATS_EN
        check({tag, "_stats"}, statsCount, 0);
`endif
    endtask

    typedef struct {
        int lx, ly, dx, dy;
        bit rd, wr;
        logic [4:0] selXy, selYx;
        bit mRd, mWr;
    } vec_t;

    vec_t vecs[9];

    // ---------------- test sequence ----------------
    initial begin
        logic [DEST_W-1:0] d;
        int op;

        vecs[0] = '{2, 2, 2, 3, 1'b0, 1'b1, SEL_N, SEL_N, 1'b0, 1'b0};
        vecs[1] = '{2, 2, 2, 2, 1'b1, 1'b0, SEL_L, SEL_L, 1'b1, 1'b0};
        vecs[2] = '{2, 2, 4, 0, 1'b1, 1'b0, SEL_E, SEL_S, 1'b0, 1'b0};
        vecs[3] = '{2, 2, 0, 4, 1'b0, 1'b1, SEL_W, SEL_N, 1'b0, 1'b0};
        vecs[4] = '{5, 1, 5, 0, 1'b0, 1'b1, SEL_S, SEL_S, 1'b0, 1'b0};
        vecs[5] = '{5, 1, 5, 1, 1'b0, 1'b1, SEL_L, SEL_L, 1'b0, 1'b1};
        vecs[6] = '{0, 7, 7, 7, 1'b1, 1'b0, SEL_E, SEL_E, 1'b0, 1'b0};
        vecs[7] = '{7, 0, 0, 0, 1'b0, 1'b1, SEL_W, SEL_W, 1'b0, 1'b0};
        vecs[8] = '{3, 3, 1, 6, 1'b1, 1'b0, SEL_W, SEL_N, 1'b0, 1'b0};

        reset = 1'b1;
        localAddr = 6'o22;
        in_valid = 1'b0;
        destinationAddressIn = '0;
        requesterAddressIn = '0;
        readIn = 1'b0;
        writeIn = 1'b0;
        outReady = 5'h1F;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkAllZero("reset");
        reset = 1'b0;

        // Routing table, one request at a time, with minimum-latency checks.
        for (int i = 0; i < 9; i++) begin
            localAddr = {3'(vecs[i].lx), 3'(vecs[i].ly)};
            d = {3'(vecs[i].dx), 3'(vecs[i].dy), 8'(i * 17)};
            push(d, 6'(i + 1), vecs[i].rd, vecs[i].wr);
            @(negedge clk);
            check("latency_edge_k", out_valid, 0);
            @(negedge clk);
            check("latency_edge_k1", out_valid, 1);
            check("vec_sel_xy", outputPortSelect, vecs[i].selXy);
            check("vec_sel_yx", outputPortSelectY, vecs[i].selYx);
            check("vec_valid_yx", out_validY, 1);
            check("vec_memRead", memRead, vecs[i].mRd);
            check("vec_memWrite", memWrite, vecs[i].mWr);
            check("vec_mem_yx", {memReadY, memWriteY}, {vecs[i].mRd, vecs[i].mWr});
            check("vec_dest", destinationAddressOut, d);
            check("vec_requester", requesterAddressOut, 6'(i + 1));
            @(negedge clk);
            check("vec_drained", out_valid, 0);
            check("vec_mem_pulse", {memRead, memWrite}, 0);
        end

        // Backpressure: DEPTH stored plus one staged, then drain in order.
        localAddr = 6'o22;
        outReady = 5'h00;
        for (int i = 0; i < DEPTH + 1; i++) push({3'(i), 3'd2, 8'(160 + i)}, 6'(i), 1'b1, 1'b0);
        @(negedge clk);
        check("full_in_ready", in_ready, 0);
        check("full_count", fifo_count, DEPTH);
        check("full_valid", out_valid, 1);
        check("full_in_ready_yx", in_readyY, 0);
        outReady = 5'h1F;
        for (int i = 0; i < DEPTH + 1; i++) begin
            check("drain_valid", out_valid, 1);
            check("drain_order", destinationAddressOut, {3'(i), 3'd2, 8'(160 + i)});
            check("drain_count", fifo_count, (i == 0) ? DEPTH : DEPTH - i);
            check("drain_in_ready", in_ready, i > 0);
            @(negedge clk);
        end
        check("drain_empty", out_valid, 0);
        check("drain_fifo_count", fifo_count, 0);

        // Both ops: consumed, flagged for one cycle, nothing stored.
        push({3'd4, 3'd4, 8'h55}, 6'd9, 1'b1, 1'b1);
        @(negedge clk);
        check("perr_pulse", protocol_err, 1);
        check("perr_count", fifo_count, 0);
        check("perr_no_valid", out_valid, 0);
        @(negedge clk);
        check("perr_one_cycle", protocol_err, 0);
        check("perr_no_valid_later", out_valid, 0);

        // Neither op: ignored silently.
        push({3'd4, 3'd4, 8'h66}, 6'd9, 1'b0, 1'b0);
        @(negedge clk);
        check("noop_no_err", protocol_err, 0);
        check("noop_count", fifo_count, 0);
        @(negedge clk);
        check("noop_no_valid", out_valid, 0);

        // Reset with three queued and one presented.
        outReady = 5'h00;
        for (int i = 0; i < 4; i++) push({3'(i), 3'd5, 8'(i)}, 6'(i), 1'b0, 1'b1);
        @(negedge clk);
        check("inflight_count", fifo_count, 3);
        check("inflight_valid", out_valid, 1);
        reset = 1'b1;
        @(negedge clk);
        checkAllZero("reset_inflight");
        reset = 1'b0;
        outReady = 5'h1F;

        // Randomized traffic against the reference model.
        @(posedge clk);
        #1;
        localAddr = 6'($urandom_range(0, 63));
        modelCheck = 1'b1;
        repeat (600) begin
            op = $urandom_range(0, 9);
            in_valid = ($urandom_range(0, 99) < 65);
            readIn = (op == 1) || (op >= 2 && op <= 5);
            writeIn = (op == 1) || (op >= 6);
            destinationAddressIn = DEST_W'($urandom);
            requesterAddressIn = ADDR_W'($urandom);
            outReady = ($urandom_range(0, 2) == 0) ? 5'h1F : 5'($urandom);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        readIn = 1'b0;
        writeIn = 1'b0;
        outReady = 5'h1F;
        repeat (DEPTH + 4) @(posedge clk);
        #1;
        modelCheck = 1'b0;
        @(negedge clk);
        check("final_idle", out_valid, 0);
        check("final_count", fifo_count, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
